// File: rtl/pcie_pkg.sv
// Shared PCIe egress types: arbiter FSM states, requester indices and bus widths.
`ifndef PCIE_DATA_WIDTH
`define PCIE_DATA_WIDTH 64
`endif
`ifndef PCIE_DATA_KW
`define PCIE_DATA_KW 8
`endif
`ifndef PCIE_TUSER_W
`define PCIE_TUSER_W 4
`endif
`ifndef XIL_TX_USER_W
`define XIL_TX_USER_W 4
`endif

package pcie_pkg;
  localparam int unsigned NUM_REQ = 3;

  typedef enum logic {IDLE, BUSY} arb_state_e;

  typedef enum logic [1:0] {
    REQ_SD = 2'd0,
    REQ_RC = 2'd1,
    REQ_RG = 2'd2
  } req_idx_e;

  function automatic req_idx_e onehot_to_req(input logic [NUM_REQ-1:0] oh);
    if (oh[2]) return REQ_RG;
    if (oh[1]) return REQ_RC;
    return REQ_SD;
  endfunction
endpackage

// File: rtl/egress_tx_arbiter_rr_arbiter3.sv
// Combinational 3-way round-robin select; search starts just after last_owner.
module rr_arbiter3
  import pcie_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_e           last_owner,
  output logic [NUM_REQ-1:0] gnt
);
  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] pick;

  // Rotate so the first candidate sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    case (last_owner)
      REQ_SD:  rot = {req[0], req[2], req[1]};
      REQ_RC:  rot = {req[1], req[0], req[2]};
      default: rot = req;
    endcase
    pick = rot & (~rot + 3'd1);
    case (last_owner)
      REQ_SD:  gnt = {pick[1], pick[0], pick[2]};
      REQ_RC:  gnt = {pick[0], pick[2], pick[1]};
      default: gnt = pick;
    endcase
  end
endmodule

// File: rtl/egress_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the PCIe TX AXIS port among sd, rc and rg.
`ifndef PCIE_DATA_WIDTH
`define PCIE_DATA_WIDTH 64
`endif
`ifndef PCIE_DATA_KW
`define PCIE_DATA_KW 8
`endif
`ifndef PCIE_TUSER_W
`define PCIE_TUSER_W 4
`endif
`ifndef XIL_TX_USER_W
`define XIL_TX_USER_W 4
`endif

module egress_tx_arbiter
  import pcie_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned TO_W        = $clog2(TIMEOUT_CYC + 1)
)(
  input  logic                        clk,
  input  logic                        rst,
  output logic                        sd_s_axis_tx_tready,
  input  logic [`PCIE_DATA_WIDTH-1:0] sd_s_axis_tx_tdata,
  input  logic [`PCIE_DATA_KW-1:0]    sd_s_axis_tx_tkeep,
  input  logic                        sd_s_axis_tx_sop,
  input  logic                        sd_s_axis_tx_eop,
  input  logic                        sd_s_axis_tx_tvalid,
  input  logic [`PCIE_TUSER_W-1:0]    sd_s_axis_tx_tuser,
  output logic                        rc_s_axis_tx_tready,
  input  logic [`PCIE_DATA_WIDTH-1:0] rc_s_axis_tx_tdata,
  input  logic [`PCIE_DATA_KW-1:0]    rc_s_axis_tx_tkeep,
  input  logic                        rc_s_axis_tx_sop,
  input  logic                        rc_s_axis_tx_eop,
  input  logic                        rc_s_axis_tx_tvalid,
  input  logic [`PCIE_TUSER_W-1:0]    rc_s_axis_tx_tuser,
  output logic                        rg_s_axis_tx_tready,
  input  logic [`PCIE_DATA_WIDTH-1:0] rg_s_axis_tx_tdata,
  input  logic [`PCIE_DATA_KW-1:0]    rg_s_axis_tx_tkeep,
  input  logic                        rg_s_axis_tx_sop,
  input  logic                        rg_s_axis_tx_eop,
  input  logic                        rg_s_axis_tx_tvalid,
  input  logic [`PCIE_TUSER_W-1:0]    rg_s_axis_tx_tuser,
  input  logic                        m_axis_tx_tready,
  output logic [`PCIE_DATA_WIDTH-1:0] m_axis_tx_tdata,
  output logic [`PCIE_DATA_KW-1:0]    m_axis_tx_tkeep,
  output logic                        m_axis_tx_tlast,
  output logic                        m_axis_tx_tvalid,
  output logic [`XIL_TX_USER_W-1:0]   m_axis_tx_tuser,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        err_timeout,
  output logic                        err_sop
);
  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  req_idx_e           last_owner_q, last_owner_d;
  logic [TO_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic               err_timeout_q, err_timeout_d;
  logic               err_sop_q, err_sop_d;

  logic [NUM_REQ-1:0] req_valid, req_sop, req_ready, arb_gnt;
  logic               sel_valid, sel_eop;

  assign req_valid = {rg_s_axis_tx_tvalid, rc_s_axis_tx_tvalid, sd_s_axis_tx_tvalid};
  assign req_sop   = {rg_s_axis_tx_sop, rc_s_axis_tx_sop, sd_s_axis_tx_sop};

  rr_arbiter3 u_rr (
    .req        (req_valid & req_sop),
    .last_owner (last_owner_q),
    .gnt        (arb_gnt)
  );

  always_comb begin
    sel_valid       = 1'b0;
    sel_eop         = 1'b0;
    m_axis_tx_tdata = '0;
    m_axis_tx_tkeep = '0;
    m_axis_tx_tuser = '0;
    case (grant_q)
      3'b001: begin
        sel_valid       = sd_s_axis_tx_tvalid;
        sel_eop         = sd_s_axis_tx_eop;
        m_axis_tx_tdata = sd_s_axis_tx_tdata;
        m_axis_tx_tkeep = sd_s_axis_tx_tkeep;
        m_axis_tx_tuser = sd_s_axis_tx_tuser[`XIL_TX_USER_W-1:0];
      end
      3'b010: begin
        sel_valid       = rc_s_axis_tx_tvalid;
        sel_eop         = rc_s_axis_tx_eop;
        m_axis_tx_tdata = rc_s_axis_tx_tdata;
        m_axis_tx_tkeep = rc_s_axis_tx_tkeep;
        m_axis_tx_tuser = rc_s_axis_tx_tuser[`XIL_TX_USER_W-1:0];
      end
      3'b100: begin
        sel_valid       = rg_s_axis_tx_tvalid;
        sel_eop         = rg_s_axis_tx_eop;
        m_axis_tx_tdata = rg_s_axis_tx_tdata;
        m_axis_tx_tkeep = rg_s_axis_tx_tkeep;
        m_axis_tx_tuser = rg_s_axis_tx_tuser[`XIL_TX_USER_W-1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_owner_d  = last_owner_q;
    stall_cnt_d   = stall_cnt_q;
    err_timeout_d = err_timeout_q;
    err_sop_d     = err_sop_q;
    req_ready     = '0;
    case (state_q)
      IDLE: begin
        // Mid-packet beats with no owner are swallowed so they cannot wedge the port.
        req_ready = req_valid & ~req_sop;
        if (|req_ready) err_sop_d = 1'b1;
        if (|arb_gnt) begin
          grant_d     = arb_gnt;
          state_d     = BUSY;
          stall_cnt_d = '0;
        end
      end
      BUSY: begin
        req_ready = grant_q & {NUM_REQ{m_axis_tx_tready}};
        if (sel_valid) begin
          stall_cnt_d = '0;
          if (m_axis_tx_tready && sel_eop) begin
            state_d      = IDLE;
            grant_d      = '0;
            last_owner_d = onehot_to_req(grant_q);
          end
        end else if (stall_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
          grant_d       = '0;
          last_owner_d  = onehot_to_req(grant_q);
          stall_cnt_d   = '0;
        end else begin
          stall_cnt_d = stall_cnt_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_owner_q  <= REQ_RG;
      stall_cnt_q   <= '0;
      err_timeout_q <= 1'b0;
      err_sop_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_owner_q  <= last_owner_d;
      stall_cnt_q   <= stall_cnt_d;
      err_timeout_q <= err_timeout_d;
      err_sop_q     <= err_sop_d;
    end
  end

  assign sd_s_axis_tx_tready = req_ready[0] & ~rst;
  assign rc_s_axis_tx_tready = req_ready[1] & ~rst;
  assign rg_s_axis_tx_tready = req_ready[2] & ~rst;
  assign m_axis_tx_tvalid    = sel_valid;
  assign m_axis_tx_tlast     = sel_eop;
  assign grant               = grant_q;
  assign err_timeout         = err_timeout_q;
  assign err_sop             = err_sop_q;
endmodule

// File: tb/tb_egress_tx_arbiter.sv
// Randomized bench for egress_tx_arbiter with a cycle-level behavioural model and per-requester scoreboards.
`ifndef PCIE_DATA_WIDTH
`define PCIE_DATA_WIDTH 64
`endif
`ifndef PCIE_DATA_KW
`define PCIE_DATA_KW 8
`endif
`ifndef PCIE_TUSER_W
`define PCIE_TUSER_W 4
`endif
`ifndef XIL_TX_USER_W
`define XIL_TX_USER_W 4
`endif

module tb_egress_tx_arbiter;
  localparam int TO = 8;
  localparam int DW = `PCIE_DATA_WIDTH;
  localparam int KW = `PCIE_DATA_KW;
  localparam int UW = `PCIE_TUSER_W;
  localparam int XW = `XIL_TX_USER_W;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          v[3];
  logic          s[3];
  logic          e[3];
  logic [DW-1:0] d[3];
  logic [KW-1:0] k[3];
  logic [UW-1:0] u[3];
  logic          sd_rdy, rc_rdy, rg_rdy;
  logic [2:0]    rdy;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic          m_last, m_valid;
  logic [XW-1:0] m_user;
  logic [2:0]    grant;
  logic          err_to, err_sop;

  int    total = 0;
  int    bad = 0;
  int    m_mode = 0;
  int    pkt_id[3] = '{0, 0, 0};
  beat_t exp_q[3][$];

  assign rdy = {rg_rdy, rc_rdy, sd_rdy};

  egress_tx_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .sd_s_axis_tx_tready(sd_rdy), .sd_s_axis_tx_tdata(d[0]), .sd_s_axis_tx_tkeep(k[0]),
    .sd_s_axis_tx_sop(s[0]), .sd_s_axis_tx_eop(e[0]), .sd_s_axis_tx_tvalid(v[0]),
    .sd_s_axis_tx_tuser(u[0]),
    .rc_s_axis_tx_tready(rc_rdy), .rc_s_axis_tx_tdata(d[1]), .rc_s_axis_tx_tkeep(k[1]),
    .rc_s_axis_tx_sop(s[1]), .rc_s_axis_tx_eop(e[1]), .rc_s_axis_tx_tvalid(v[1]),
    .rc_s_axis_tx_tuser(u[1]),
    .rg_s_axis_tx_tready(rg_rdy), .rg_s_axis_tx_tdata(d[2]), .rg_s_axis_tx_tkeep(k[2]),
    .rg_s_axis_tx_sop(s[2]), .rg_s_axis_tx_eop(e[2]), .rg_s_axis_tx_tvalid(v[2]),
    .rg_s_axis_tx_tuser(u[2]),
    .m_axis_tx_tready(m_ready), .m_axis_tx_tdata(m_data), .m_axis_tx_tkeep(m_keep),
    .m_axis_tx_tlast(m_last), .m_axis_tx_tvalid(m_valid), .m_axis_tx_tuser(m_user),
    .grant(grant), .err_timeout(err_to), .err_sop(err_sop)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Core ready: 0 = always, 1 = toggling, 2 = random ~75%.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (m_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Behavioural model: owner/last/stall as plain integers, advanced once per cycle.
  bit            mdl_busy, mdl_err_to, mdl_err_sop;
  int            mdl_own, mdl_last, mdl_stall, cand;
  bit            exp_rdy, prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  beat_t         got;

  always @(negedge clk) begin
    if (rst) begin
      mdl_busy = 0; mdl_own = 0; mdl_last = 2; mdl_stall = 0;
      mdl_err_to = 0; mdl_err_sop = 0; prev_stall = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        exp_rdy = mdl_busy ? (i == mdl_own && m_ready) : (v[i] && !s[i]);
        check($sformatf("tready[%0d]", i), 64'(rdy[i]), 64'(exp_rdy));
      end
      check("grant", 64'(grant), mdl_busy ? 64'(1 << mdl_own) : 64'd0);
      check("m_tvalid", 64'(m_valid), mdl_busy ? 64'(v[mdl_own]) : 64'd0);
      check("err_timeout", 64'(err_to), 64'(mdl_err_to));
      check("err_sop", 64'(err_sop), 64'(mdl_err_sop));
      if (mdl_busy && v[mdl_own]) begin
        check("m_tdata", m_data, d[mdl_own]);
        check("m_tkeep", 64'(m_keep), 64'(k[mdl_own]));
        check("m_tuser", 64'(m_user), 64'(u[mdl_own][XW-1:0]));
        check("m_tlast", 64'(m_last), 64'(e[mdl_own]));
      end
      if (prev_stall) begin
        check("hold_tvalid", 64'(m_valid), 64'd1);
        check("hold_tdata", m_data, prev_data);
        check("hold_tlast", 64'(m_last), 64'(prev_last));
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (mdl_busy && m_valid && m_ready) begin
        if (exp_q[mdl_own].size() == 0) begin
          total++; bad++;
          $display("FAIL sb_extra: got unexpected beat %0h from req %0d, expected none", m_data, mdl_own);
        end else begin
          got = exp_q[mdl_own].pop_front();
          check("sb_data", m_data, got.data);
          check("sb_last", 64'(m_last), 64'(got.last));
        end
      end
      if (!mdl_busy) begin
        for (int i = 0; i < 3; i++) if (v[i] && !s[i]) mdl_err_sop = 1;
        for (int n = 1; n <= 3; n++) begin
          cand = (mdl_last + n) % 3;
          if (!mdl_busy && v[cand] && s[cand]) begin
            mdl_busy = 1; mdl_own = cand; mdl_stall = 0;
          end
        end
      end else if (v[mdl_own]) begin
        mdl_stall = 0;
        if (m_ready && e[mdl_own]) begin mdl_busy = 0; mdl_last = mdl_own; end
      end else begin
        mdl_stall++;
        if (mdl_stall == TO) begin
          mdl_err_to = 1; mdl_busy = 0; mdl_last = mdl_own; mdl_stall = 0;
        end
      end
    end
  end

  task automatic send_pkt(input int r, input int nb, input int gap_max);
    beat_t b;
    bit    hs;
    int    waited;
    for (int i = 0; i < nb; i++) begin
      if (i > 0) repeat ($urandom_range(0, gap_max)) begin v[r] = 1'b0; @(posedge clk); #1; end
      b.data = {8'(r), 8'(pkt_id[r]), 16'(i), 32'($urandom)};
      b.keep = KW'($urandom);
      b.user = UW'($urandom);
      b.last = (i == nb - 1);
      v[r] = 1'b1; s[r] = (i == 0); e[r] = b.last;
      d[r] = b.data; k[r] = b.keep; u[r] = b.user;
      exp_q[r].push_back(b);
      hs = 0; waited = 0;
      while (!hs) begin
        @(negedge clk); hs = rdy[r];
        @(posedge clk); #1;
        waited++;
        if (!hs && waited > 300) begin
          total++; bad++;
          $display("FAIL handshake_bound: req %0d got no tready, expected one within 300 cycles", r);
          v[r] = 1'b0; s[r] = 1'b0; e[r] = 1'b0;
          return;
        end
      end
    end
    pkt_id[r]++;
    v[r] = 1'b0; s[r] = 1'b0; e[r] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1);
  end

  initial begin : main
    int    tl_cyc[$];
    int    tl_gnt[$];
    int    n, rc_pk, waited;
    bit    seen, hs;
    beat_t b;
    for (int i = 0; i < 3; i++) begin
      v[i] = 0; s[i] = 0; e[i] = 0; d[i] = '0; k[i] = '0; u[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    repeat (10) @(negedge clk);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_mvalid", 64'(m_valid), 64'd0);
    check("rst_tready", 64'(rdy), 64'd0);
    @(posedge clk); #1;

    // All three request at once: sd, rc, rg in turn with one bubble each.
    fork
      send_pkt(0, 3, 0);
      send_pkt(1, 3, 0);
      send_pkt(2, 3, 0);
      begin
        n = 0; seen = 0;
        repeat (30) begin
          @(negedge clk);
          if (m_valid) seen = 1;
          if (seen) n++;
          if (m_valid && m_ready && m_last) begin
            tl_cyc.push_back(n); tl_gnt.push_back(int'(grant));
          end
        end
      end
    join
    check("rr_tlast_count", 64'(tl_cyc.size()), 64'd3);
    for (int j = 0; j < 3; j++) if (j < tl_cyc.size()) begin
      check("rr_tlast_cycle", 64'(tl_cyc[j]), 64'(3 + 4 * j));
      check("rr_order", 64'(tl_gnt[j]), 64'(1 << j));
    end
    @(posedge clk); #1;

    // Lone rc requester is re-granted for every packet.
    fork
      for (int p = 0; p < 4; p++) send_pkt(1, $urandom_range(1, 5), 2);
      begin
        rc_pk = 0;
        repeat (80) begin
          @(negedge clk);
          if (m_valid && m_ready && m_last) begin
            rc_pk++;
            check("rc_grant", 64'(grant), 64'b010);
          end
        end
      end
    join
    check("rc_pkt_count", 64'(rc_pk), 64'd4);

    m_mode = 1;
    send_pkt(0, 6, 0);
    m_mode = 0;
    repeat (2) @(negedge clk);
    check("toggle_no_timeout", 64'(err_to), 64'd0);
    @(posedge clk); #1;

    m_mode = 2;
    fork
      for (int p = 0; p < 6; p++) send_pkt(0, $urandom_range(1, 6), 3);
      for (int p = 0; p < 6; p++) send_pkt(1, $urandom_range(1, 6), 3);
      for (int p = 0; p < 6; p++) send_pkt(2, $urandom_range(1, 6), 3);
    join
    m_mode = 0;
    repeat (3) @(posedge clk);
    #1;

    // sd sends its sop beat then goes silent; rc queues behind it.
    b.data = DW'({$urandom, $urandom}); b.keep = '1; b.user = '0; b.last = 1'b0;
    v[0] = 1'b1; s[0] = 1'b1; e[0] = 1'b0; d[0] = b.data; k[0] = b.keep; u[0] = b.user;
    exp_q[0].push_back(b);
    hs = 0; waited = 0;
    while (!hs && waited < 50) begin
      @(negedge clk); hs = sd_rdy;
      @(posedge clk); #1;
      waited++;
    end
    check("to_sop_accepted", 64'(hs), 64'd1);
    v[0] = 1'b0; s[0] = 1'b0;
    fork
      send_pkt(1, 2, 0);
      begin
        repeat (8) @(negedge clk);
        check("to_not_yet", 64'(err_to), 64'd0);
        check("to_grant_held", 64'(grant), 64'b001);
        @(negedge clk);
        check("to_fired", 64'(err_to), 64'd1);
        check("to_grant_idle", 64'(grant), 64'd0);
        @(negedge clk);
        check("to_next_rc", 64'(grant), 64'b010);
      end
    join

    check("sop_clean", 64'(err_sop), 64'd0);
    @(posedge clk); #1;
    v[2] = 1'b1; s[2] = 1'b0; e[2] = 1'b0; d[2] = DW'({$urandom, $urandom});
    @(negedge clk);
    check("drop_rg_ready", 64'(rg_rdy), 64'd1);
    check("drop_mvalid", 64'(m_valid), 64'd0);
    @(posedge clk); #1;
    v[2] = 1'b0;
    @(negedge clk);
    check("drop_err_sop", 64'(err_sop), 64'd1);
    check("drop_grant", 64'(grant), 64'd0);
    check("drop_mvalid2", 64'(m_valid), 64'd0);

    repeat (2) @(negedge clk);
    for (int r = 0; r < 3; r++) check($sformatf("sb_drain[%0d]", r), 64'(exp_q[r].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/egress_tx_arbiter.md
# egress_tx_arbiter

Packet-level round-robin arbiter that shares the single PCIe core TX AXIS port (m_axis_tx_*) among the three action modules: fpga send (sd), fpga receive (rc) and fpga register (rg). A grant is held from sop to eop, so TLPs are never interleaved. The block sits between the action modules' TX outputs and the ingress/egress top-level TX port. It also reports sticky protocol errors: a stalled packet and a missing sop.

## Interface
Parameters:
- TIMEOUT_CYC, 1024: consecutive cycles a granted requester may hold tvalid low mid-packet before err_timeout is raised.
- TO_W, $clog2(TIMEOUT_CYC+1): stall-counter width.

Ports (X ∈ {sd, rc, rg}):
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- X_s_axis_tx_tready  out  1  ready to requester X
- X_s_axis_tx_tdata  in  `PCIE_DATA_WIDTH  requester data
- X_s_axis_tx_tkeep  in  `PCIE_DATA_KW  byte enables
- X_s_axis_tx_sop  in  1  first beat of TLP
- X_s_axis_tx_eop  in  1  last beat of TLP
- X_s_axis_tx_tvalid  in  1  beat valid
- X_s_axis_tx_tuser  in  `PCIE_TUSER_W  sideband
- m_axis_tx_tready  in  1  core ready
- m_axis_tx_tdata  out  `PCIE_DATA_WIDTH  to core
- m_axis_tx_tkeep  out  `PCIE_DATA_KW  to core
- m_axis_tx_tlast  out  1  equals granted eop
- m_axis_tx_tvalid  out  1  to core
- m_axis_tx_tuser  out  `XIL_TX_USER_W  granted tuser[`XIL_TX_USER_W-1:0]
- grant  out  3  one-hot current owner {rg,rc,sd}; 0 when idle
- err_timeout  out  1  sticky: stall timeout fired
- err_sop  out  1  sticky: non-sop beat seen while idle

## Operation
- FSM states: IDLE, BUSY.
- IDLE:
  - Requester eligible iff tvalid & sop.
  - Winner chosen round-robin, starting at the index after last_owner; order sd(0), rc(1), rg(2).
  - Registered grant <= winner; state -> BUSY.
  - All tready = 0 for sop beats. The sop beat is held, not consumed, until BUSY.
  - A requester with tvalid & !sop while IDLE gets tready=1 that cycle; the beat is dropped and err_sop is set.
- BUSY:
  - Combinational mux from grant: m_tvalid = X_tvalid, m_tdata/tkeep/tuser = X's, m_tlast = X_eop.
  - X_tready = m_axis_tx_tready; non-granted tready = 0.
  - On a beat with X_tvalid & m_tready & X_eop: state -> IDLE, last_owner <= X, grant <= 0.
  - Stall counter: cleared on any accepted beat or X_tvalid=1. Increments while X_tvalid=0. On reaching TIMEOUT_CYC: err_timeout set, state forced to IDLE (packet abandoned), last_owner <= X.
  - The counter does not increment during core backpressure (X_tvalid=1, m_tready=0).
- Sop on a non-first beat while BUSY is forwarded unchanged; it is not checked.
- Reset: state=IDLE, grant=0, last_owner=rg (so sd wins first), counter=0, err_*=0, all tready=0, m_axis_tx_tvalid=0. Reset mid-packet abandons the packet silently.

## Timing
- Arbitration latency: sop presented in IDLE -> first beat on m_axis_tx one cycle later (one bubble per packet).
- Steady state in BUSY: zero-latency pass-through, one beat/cycle when the core is ready.
- Back-to-back packets: eop accepted at cycle n, next packet's sop accepted no earlier than n+2.
- m_axis_tx_* must stay stable while tvalid & !tready. This holds because the grant is fixed during BUSY and requesters obey AXIS.
- Simultaneous requests from all three are served sd→rc→rg→sd…; a lone requester is re-granted each time.
- err_* are cleared only by rst.

## Structure
- Shared package (pcie_pkg): arb_state_e {IDLE, BUSY}; requester index enum {REQ_SD, REQ_RC, REQ_RG}; NUM_REQ=3.
- Natural sub-module: rr_arbiter3 (combinational round-robin select from eligible vector + last_owner, one-hot out). FSM, mux and counter stay in the top.

## Test plan
- Reset release, all tvalid=0 → grant=0, m_axis_tx_tvalid=0, all tready=0 for 10 cycles.
- sd, rc, rg each present a 3-beat TLP at cycle 0, m_tready=1 → output order sd, rc, rg; 3 beats each; one idle cycle between packets; tlast on beats 3, 7, 11 of the output stream (counting from first output beat).
- rc sends 4 TLPs back-to-back alone → all granted to rc; grant=3'b010 during each; no data loss.
- Granted sd packet with m_tready toggling 1/0 every cycle → every beat delivered once; m_* stable while stalled; err_timeout stays 0.
- TIMEOUT_CYC=8, sd drops tvalid after beat 1 → err_timeout=1 at the 8th idle cycle, FSM returns to IDLE, pending rc packet is granted next.
- rg asserts tvalid with sop=0 while IDLE → rg_tready=1 for that cycle, err_sop=1, nothing appears on m_axis_tx.
